// File: rtl/uart_calc_seq_pkg.sv
// Shared definitions for the UART calculator sequencer.
// Holds the FSM state encoding, the op_code and res_err encodings, the ASCII
// byte constants recognised on the receive stream, and small decode helpers.
package uart_calc_seq_pkg;

    typedef enum logic [2:0] {
        S_GET_A     = 3'd0,
        S_GET_OP    = 3'd1,
        S_GET_B     = 3'd2,
        S_EXEC      = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESULT    = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_ALU = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;  // carriage return: ignored like any other unlisted byte
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_MUL   = 8'h2A;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_DIV   = 8'h2F;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    // True for an ASCII decimal digit '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    // Operator byte decode: bit 2 = recognised operator, bits 1:0 = op_code.
    function automatic logic [2:0] op_decode(input logic [7:0] b);
        logic [2:0] r;
        case (b)
            ASC_PLUS:  r = {1'b1, OP_ADD};
            ASC_MINUS: r = {1'b1, OP_SUB};
            ASC_MUL:   r = {1'b1, OP_MUL};
            ASC_DIV:   r = {1'b1, OP_DIV};
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_calc_seq_dec_accum.sv
// dec_accum: decimal operand accumulator.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   byte_valid   - a received byte is presented and the FSM is collecting an operand
//   byte_data    - received byte
//   clr_acc      - clear accumulator and digit counter (operand end or ESC)
//   clr_ovf      - clear the sticky overflow flag (ESC or result accepted)
//   acc          - accumulated value, acc*10+digit modulo 2^WIDTH
//   cnt_nz       - at least one digit has been accumulated
//   ovf          - sticky: a digit arrived after MAX_DIGITS digits were taken
module dec_accum
    import uart_calc_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             clr_acc,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             cnt_nz,
    output logic             ovf
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             digit_s;
    logic             at_max_s;
    logic [WIDTH-1:0] acc_nxt_s;

    // Digit detect and next accumulator value (x*10 as x*8 + x*2).
    always_comb begin
        digit_s   = byte_valid && is_digit(byte_data);
        at_max_s  = (cnt_r == CNT_W'(MAX_DIGITS));
        acc_nxt_s = (acc_r << 3'd3) + (acc_r << 3'd1) + WIDTH'(byte_data[3:0]);
    end

    // Accumulator and digit counter; a digit beyond the limit leaves both untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (clr_acc) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (digit_s && !at_max_s) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sticky overflow flag; clearing wins over a simultaneous set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_r <= 1'b0;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end else if (digit_s && at_max_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign acc    = acc_r;
    assign cnt_nz = (cnt_r != '0);
    assign ovf    = ovf_r;

endmodule

// File: rtl/uart_calc_seq.sv
// uart_calc_seq: parses "<a>LF<op><b>LF" from a UART byte stream, drives an
// external arithmetic unit and presents the result with a valid/ready handshake.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   rx_data, rx_valid      - received byte and its one-cycle strobe
//   op_a, op_b, op_code    - operands and operation to the arithmetic unit
//   alu_start              - one-cycle start pulse
//   alu_done, alu_result, alu_err - completion strobe, result and error flag
//   res_valid, res_ready   - result handshake
//   res_data, res_err      - result value and status
//   busy                   - high whenever the block is not waiting for operand A
module uart_calc_seq
    import uart_calc_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DIGITS  = 9,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       op_code,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_err,
    output logic             busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMO_W-1:0] tmo_cnt_r;

    logic [WIDTH-1:0] acc_s;
    logic             cnt_nz_s;
    logic             ovf_s;
    logic             acc_en_s;
    logic             clr_acc_s;
    logic             clr_ovf_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             load_op_s;
    logic             start_s;
    logic             done_cap_s;
    logic             tmo_s;
    logic             ovf_res_s;
    logic             accept_s;
    logic [2:0]       op_dec_s;
    logic             esc_s;
    logic             lf_end_s;

    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic [1:0]       op_code_r;
    logic             alu_start_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic [1:0]       res_err_r;
    logic             busy_r;

    dec_accum #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_dec_accum (
        .clk        (clk),
        .resetn     (resetn),
        .byte_valid (acc_en_s),
        .byte_data  (rx_data),
        .clr_acc    (clr_acc_s),
        .clr_ovf    (clr_ovf_s),
        .acc        (acc_s),
        .cnt_nz     (cnt_nz_s),
        .ovf        (ovf_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_GET_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        acc_en_s    = 1'b0;
        clr_acc_s   = 1'b0;
        clr_ovf_s   = 1'b0;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        load_op_s   = 1'b0;
        start_s     = 1'b0;
        done_cap_s  = 1'b0;
        tmo_s       = 1'b0;
        ovf_res_s   = 1'b0;
        accept_s    = 1'b0;
        op_dec_s    = op_decode(rx_data);
        esc_s       = rx_valid && (rx_data == ASC_ESC);
        // An LF only ends an operand once at least one digit was seen.
        lf_end_s    = rx_valid && (rx_data == ASC_LF) && cnt_nz_s;
        case (state_r)
            S_GET_A: begin
                acc_en_s = rx_valid;
                if (esc_s) begin
                    clr_acc_s = 1'b1;
                    clr_ovf_s = 1'b1;
                end else if (lf_end_s) begin
                    load_a_s    = 1'b1;
                    clr_acc_s   = 1'b1;
                    state_nxt_s = S_GET_OP;
                end else begin
                    state_nxt_s = S_GET_A;
                end
            end
            S_GET_OP: begin
                if (esc_s) begin
                    clr_acc_s   = 1'b1;
                    clr_ovf_s   = 1'b1;
                    state_nxt_s = S_GET_A;
                end else if (rx_valid && op_dec_s[2]) begin
                    load_op_s   = 1'b1;
                    state_nxt_s = S_GET_B;
                end else begin
                    state_nxt_s = S_GET_OP;
                end
            end
            S_GET_B: begin
                acc_en_s = rx_valid;
                if (esc_s) begin
                    clr_acc_s   = 1'b1;
                    clr_ovf_s   = 1'b1;
                    state_nxt_s = S_GET_A;
                end else if (lf_end_s) begin
                    load_b_s    = 1'b1;
                    clr_acc_s   = 1'b1;
                    // The start pulse is registered, so it is decided here
                    // and appears exactly during the EXEC cycle.
                    start_s     = !ovf_s;
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_GET_B;
                end
            end
            S_EXEC: begin
                if (ovf_s) begin
                    ovf_res_s   = 1'b1;
                    state_nxt_s = S_RESULT;
                end else begin
                    state_nxt_s = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (alu_done) begin
                    done_cap_s  = 1'b1;
                    state_nxt_s = S_RESULT;
                end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Counter would reach TIMEOUT_CYC on this edge.
                    tmo_s       = 1'b1;
                    state_nxt_s = S_RESULT;
                end else begin
                    state_nxt_s = S_WAIT_DONE;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    accept_s    = 1'b1;
                    clr_ovf_s   = 1'b1;
                    state_nxt_s = S_GET_A;
                end else begin
                    state_nxt_s = S_RESULT;
                end
            end
            default: begin
                state_nxt_s = S_GET_A;
            end
        endcase
    end

    // Wait-for-done cycle counter: zero on the first WAIT_DONE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r <= '0;
        end else if (state_r != S_WAIT_DONE) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Operand, operation and control output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_code_r   <= 2'b00;
            alu_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            alu_start_r <= start_s;
            busy_r      <= (state_nxt_s != S_GET_A);
            if (load_a_s) begin
                op_a_r <= acc_s;
            end
            if (load_b_s) begin
                op_b_r <= acc_s;
            end
            if (load_op_s) begin
                op_code_r <= op_dec_s[1:0];
            end
        end
    end

    // Result registers and handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_err_r   <= ERR_OK;
        end else if (done_cap_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= alu_result;
            res_err_r   <= alu_err ? ERR_ALU : ERR_OK;
        end else if (tmo_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= '0;
            res_err_r   <= ERR_TMO;
        end else if (ovf_res_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= '0;
            res_err_r   <= ERR_OVF;
        end else if (accept_s) begin
            res_valid_r <= 1'b0;
        end
    end

    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign op_code   = op_code_r;
    assign alu_start = alu_start_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_err   = res_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_calc_seq.sv
// Self-checking bench for uart_calc_seq: directed scenarios plus randomized
// expressions checked against a decimal/arithmetic reference model.
module tb_uart_calc_seq;

    localparam int WIDTH       = 32;
    localparam int MAX_DIGITS  = 9;
    localparam int TIMEOUT_CYC = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;
    logic             alu_start;
    logic             alu_done = 1'b0;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_err = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_data;
    logic [1:0]       res_err;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_calc_seq #(
        .WIDTH       (WIDTH),
        .MAX_DIGITS  (MAX_DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_code    (op_code),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One byte per cycle; returns 1 time unit after the consuming edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(8'h0A);
    endtask

    // Random digits; the model keeps only the first MAX_DIGITS of them.
    task automatic send_digits(input int nd, output longint val);
        int d;
        val = 0;
        for (int i = 0; i < nd; i++) begin
            d = $urandom_range(0, 9);
            send_byte(8'h30 + 8'(d));
            if (i < MAX_DIGITS) begin
                val = val * 10 + d;
            end
        end
    endtask

    function automatic logic [7:0] op_char(input int op);
        case (op)
            0:       return 8'h2B;
            1:       return 8'h2D;
            2:       return 8'h2A;
            default: return 8'h2F;
        endcase
    endfunction

    // Arithmetic unit reference: 32-bit wrapping results.
    function automatic logic [31:0] alu_model(input longint a, input longint b, input int op);
        longint r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        return r[31:0];
    endfunction

    task automatic finish_txn(input bit ovf, input longint a, input longint b, input int op,
                              input bit force_err, input int dly, input int hold);
        bit          seen;
        bit          got_v;
        logic [31:0] res;
        bit          err;
        logic [31:0] a32;
        logic [31:0] b32;
        a32 = a[31:0];
        b32 = b[31:0];
        seen = 1'b0;
        if (!ovf) begin
            for (int i = 0; i < 4 && !seen; i++) begin
                if (alu_start) seen = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check_eq("alu_start_seen", seen, 1);
            check_eq("op_a", op_a, a32);
            check_eq("op_b", op_b, b32);
            check_eq("op_code", op_code, op);
            @(posedge clk); #1;
            check_eq("alu_start_one_cycle", alu_start, 0);
            repeat (dly) @(posedge clk);
            res = alu_model(a, b, op);
            err = force_err || (op == 3 && b == 0);
            @(negedge clk);
            alu_done   = 1'b1;
            alu_result = res;
            alu_err    = err;
            @(posedge clk); #1;
            alu_done = 1'b0;
            alu_err  = 1'b0;
            check_eq("res_valid", res_valid, 1);
            check_eq("res_data", res_data, res);
            check_eq("res_err", res_err, err ? 2'b01 : 2'b00);
        end else begin
            got_v = 1'b0;
            for (int i = 0; i < 4 && !got_v; i++) begin
                if (alu_start) seen = 1'b1;
                if (res_valid) got_v = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check_eq("ovf_no_start", seen, 0);
            check_eq("ovf_res_valid", got_v, 1);
            check_eq("ovf_res_err", res_err, 2'b10);
        end
        // Bytes offered while the result waits must be dropped.
        for (int i = 0; i < hold; i++) begin
            case ($urandom_range(0, 3))
                0:       send_byte(8'h35);
                1:       send_byte(8'h0A);
                2:       send_byte(8'h1B);
                default: send_byte(8'h2B);
            endcase
        end
        check_eq("res_valid_held", res_valid, 1);
        check_eq("busy_in_result", busy, 1);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq("res_valid_cleared", res_valid, 0);
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic run_random();
        int     na;
        int     nb;
        int     op;
        longint a;
        longint b;
        na = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(1, 9);
        nb = ($urandom_range(0, 7) == 0) ? 11 : $urandom_range(1, 9);
        case ($urandom_range(0, 3))
            0:       send_byte(8'h0D);
            1:       send_byte(8'h0A);
            2:       send_byte(8'h78);
            default: ;
        endcase
        send_digits(na, a);
        send_byte(8'h0A);
        check_eq("busy_after_a", busy, 1);
        if ($urandom_range(0, 1) == 1) send_byte(8'h0D);
        op = $urandom_range(0, 3);
        send_byte(op_char(op));
        send_digits(nb, b);
        send_byte(8'h0A);
        finish_txn((na > MAX_DIGITS) || (nb > MAX_DIGITS), a, b, op,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 8), $urandom_range(0, 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        bit early;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_op_a", op_a, 0);
        check_eq("rst_op_b", op_b, 0);
        check_eq("rst_ctrl", {op_code, alu_start, res_valid, res_err, busy}, 0);
        check_eq("rst_res_data", res_data, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Division with CR ignored in GET_OP.
        send_line("1234");
        send_byte(8'h0D);
        send_line("/5");
        finish_txn(1'b0, 1234, 5, 3, 1'b0, 2, 0);

        // Empty LF in GET_OP ignored.
        send_line("7");
        send_line("+");
        send_line("3");
        finish_txn(1'b0, 7, 3, 0, 1'b0, 0, 1);

        // Ten-digit operand overflows.
        send_line("1234567890");
        send_line("*2");
        finish_txn(1'b1, 0, 0, 2, 1'b0, 0, 2);

        // Divide by zero, result held 20 cycles with traffic dropped.
        send_line("9");
        send_line("/0");
        finish_txn(1'b0, 9, 0, 3, 1'b0, 1, 20);

        // ESC discards partial operand.
        send_str("12");
        send_byte(8'h1B);
        send_line("3");
        send_line("-1");
        finish_txn(1'b0, 3, 1, 1, 1'b0, 3, 0);

        // Stray alu_done outside WAIT_DONE is ignored.
        @(negedge clk);
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_eq("stray_done_ignored", res_valid, 0);

        // Timeout: no alu_done.
        send_line("5");
        send_line("+6");
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (alu_start) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_eq("tmo_start_seen", seen, 1);
        early = 1'b0;
        for (int k = 0; k < TIMEOUT_CYC; k++) begin
            @(posedge clk); #1;
            if (res_valid) early = 1'b1;
        end
        check_eq("tmo_not_early", early, 0);
        @(posedge clk); #1;
        check_eq("tmo_res_valid", res_valid, 1);
        check_eq("tmo_res_err", res_err, 2'b11);
        check_eq("tmo_res_data", res_data, 0);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq("tmo_accept", res_valid, 0);

        // Reset during WAIT_DONE.
        send_line("8");
        send_line("*4");
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq("midrst_op_a", op_a, 0);
        check_eq("midrst_op_b", op_b, 0);
        check_eq("midrst_ctrl", {op_code, alu_start, res_valid, res_err, busy}, 0);
        check_eq("midrst_res_data", res_data, 0);
        alu_done = 1'b1;
        @(posedge clk); #1;
        alu_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (alu_start || res_valid || busy) seen = 1'b1;
        end
        check_eq("after_rst_idle", seen, 0);

        // Randomized expressions.
        for (int t = 0; t < 24; t++) begin
            run_random();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
